// File: rtl/output_deskew_buffer.sv
// output_deskew_buffer: realigns skewed systolic column results into rows and queues them in a FWFT FIFO; define DESKEW_RELU_EN to clamp negative fields to zero on FIFO write
module output_deskew_buffer #(
  parameter int ACC_WIDTH  = 20,
  parameter int NUM_COLS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_COLS-1:0]           in_valid,
  input  logic [NUM_COLS*ACC_WIDTH-1:0] data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_COLS*ACC_WIDTH-1:0] data_out,
  output logic                          full,
  output logic                          overflow,
  output logic                          skew_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = NUM_COLS * ACC_WIDTH;
  logic [NUM_COLS-1:0]  dv;
  logic [ACC_WIDTH-1:0] dd [NUM_COLS];
  logic [RW-1:0]        row;
  logic [RW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop, accept;
  genvar c;
  for (c = 0; c < NUM_COLS; c++) begin : g_col
    if (c == NUM_COLS - 1) begin : g_direct
      assign dv[c] = in_valid[c];
      assign dd[c] = data_in[c*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      localparam int S = NUM_COLS - 1 - c;
      logic [S-1:0]         v;
      logic [ACC_WIDTH-1:0] d [S];
      // free-running shift line: earlier columns wait longer so the row lines up with the last column
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v <= '0;
          for (int i = 0; i < S; i++) d[i] <= '0;
        end else if (flush) begin
          v <= '0;
          for (int i = 0; i < S; i++) d[i] <= '0;
        end else begin
          for (int i = S - 1; i > 0; i--) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
          end
          v[0] <= in_valid[c];
          d[0] <= data_in[c*ACC_WIDTH +: ACC_WIDTH];
        end
      assign dv[c] = v[S-1];
      assign dd[c] = d[S-1];
    end
  end
  // assemble the aligned row, optionally clamping negative sums
  always_comb begin
    row = '0;
    for (int i = 0; i < NUM_COLS; i++)
`ifdef DESKEW_RELU_EN
      row[i*ACC_WIDTH +: ACC_WIDTH] = dd[i][ACC_WIDTH-1] ? '0 : dd[i];
`else
      row[i*ACC_WIDTH +: ACC_WIDTH] = dd[i];
`endif
  end
  assign push      = &dv;
  assign out_valid = count != '0;
  assign full      = count == CW'(FIFO_DEPTH);
  assign pop       = out_valid & out_ready;
  assign accept    = push & (~full | pop);
  assign data_out  = out_valid ? mem[rd_ptr] : '0;
  // row storage; contents are don't-care outside the live window so no reset is needed
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= row;
  // FIFO bookkeeping and sticky error flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
      if (push & full & ~pop) overflow <= 1'b1;
      if ((|dv) & ~push) skew_err <= 1'b1;
    end
endmodule
